// File: rtl/ppi_mode1_handshake.sv
// Mode 1 strobed-I/O handshake engine for one 8255-style PPI port (group A or B).
// Define PPI_HS_SYNC_EN to add 2-flop synchronizers on stb_n/ack_n/rd_n/wr_n/pd_in.
module ppi_mode1_handshake #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ACK_MIN_CYC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode_in,
    input  logic             inte,
    input  logic             sel,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [WIDTH-1:0] cpu_din,
    output logic [WIDTH-1:0] cpu_dout,
    input  logic             stb_n,
    input  logic             ack_n,
    input  logic [WIDTH-1:0] pd_in,
    output logic [WIDTH-1:0] pd_out,
    output logic             pd_oe,
    output logic             ibf,
    output logic             obf_n,
    output logic             intr,
    output logic             overrun
);

    localparam int unsigned       CNT_W   = $clog2(ACK_MIN_CYC + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MIN = CNT_W'(ACK_MIN_CYC);

    typedef enum logic [1:0] {IN_EMPTY, IN_FULL, IN_READ} in_state_t;
    typedef enum logic [1:0] {OUT_EMPTY, OUT_FULL, OUT_ACK} out_state_t;

    logic             stb_s;
    logic             ack_s;
    logic             rd_s;
    logic             wr_s;
    logic [WIDTH-1:0] pd_s;

`ifdef PPI_HS_SYNC_EN
    // Two-stage synchronizers; strobes idle high, data idles low.
    logic [1:0]       stb_sync;
    logic [1:0]       ack_sync;
    logic [1:0]       rd_sync;
    logic [1:0]       wr_sync;
    logic [WIDTH-1:0] pd_sync0;
    logic [WIDTH-1:0] pd_sync1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stb_sync <= 2'b11;
            ack_sync <= 2'b11;
            rd_sync  <= 2'b11;
            wr_sync  <= 2'b11;
            pd_sync0 <= '0;
            pd_sync1 <= '0;
        end else begin
            stb_sync <= {stb_sync[0], stb_n};
            ack_sync <= {ack_sync[0], ack_n};
            rd_sync  <= {rd_sync[0], rd_n};
            wr_sync  <= {wr_sync[0], wr_n};
            pd_sync0 <= pd_in;
            pd_sync1 <= pd_sync0;
        end
    end

    assign stb_s = stb_sync[1];
    assign ack_s = ack_sync[1];
    assign rd_s  = rd_sync[1];
    assign wr_s  = wr_sync[1];
    assign pd_s  = pd_sync1;
`else
    assign stb_s = stb_n;
    assign ack_s = ack_n;
    assign rd_s  = rd_n;
    assign wr_s  = wr_n;
    assign pd_s  = pd_in;
`endif

    logic             stb_q;
    logic             ack_q;
    logic             rd_q;
    logic             wr_q;
    logic             mode_q;
    in_state_t        in_state;
    in_state_t        in_state_nx;
    out_state_t       out_state;
    out_state_t       out_state_nx;
    logic [CNT_W-1:0] ack_cnt;
    logic [CNT_W-1:0] ack_cnt_nx;
    logic [WIDTH-1:0] cpu_dout_nx;
    logic [WIDTH-1:0] pd_out_nx;
    logic             pd_oe_nx;
    logic             ibf_nx;
    logic             obf_n_nx;
    logic             intr_nx;
    logic             overrun_nx;

    logic stb_fall_c;
    logic stb_rise_c;
    logic ack_fall_c;
    logic ack_rise_c;
    logic rd_fall_c;
    logic rd_rise_c;
    logic wr_fall_c;
    logic wr_rise_c;
    logic mode_chg_c;

    // CPU strobe edges only count while the port is selected.
    assign stb_fall_c = stb_q & ~stb_s;
    assign stb_rise_c = ~stb_q & stb_s;
    assign ack_fall_c = ack_q & ~ack_s;
    assign ack_rise_c = ~ack_q & ack_s;
    assign rd_fall_c  = sel & rd_q & ~rd_s;
    assign rd_rise_c  = sel & ~rd_q & rd_s;
    assign wr_fall_c  = sel & wr_q & ~wr_s;
    assign wr_rise_c  = sel & ~wr_q & wr_s;
    assign mode_chg_c = mode_in ^ mode_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stb_q     <= 1'b1;
            ack_q     <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            mode_q    <= mode_in;
            in_state  <= IN_EMPTY;
            out_state <= OUT_EMPTY;
            ack_cnt   <= '0;
            cpu_dout  <= '0;
            pd_out    <= '0;
            pd_oe     <= 1'b0;
            ibf       <= 1'b0;
            obf_n     <= 1'b1;
            intr      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            stb_q     <= stb_s;
            ack_q     <= ack_s;
            rd_q      <= rd_s;
            wr_q      <= wr_s;
            mode_q    <= mode_in;
            in_state  <= in_state_nx;
            out_state <= out_state_nx;
            ack_cnt   <= ack_cnt_nx;
            cpu_dout  <= cpu_dout_nx;
            pd_out    <= pd_out_nx;
            pd_oe     <= pd_oe_nx;
            ibf       <= ibf_nx;
            obf_n     <= obf_n_nx;
            intr      <= intr_nx;
            overrun   <= overrun_nx;
        end
    end

    always_comb begin
        in_state_nx  = in_state;
        out_state_nx = out_state;
        ack_cnt_nx   = ack_cnt;
        cpu_dout_nx  = cpu_dout;
        pd_out_nx    = pd_out;
        pd_oe_nx     = ~mode_in;
        ibf_nx       = ibf;
        obf_n_nx     = obf_n;
        intr_nx      = intr;
        overrun_nx   = overrun;

        if (mode_chg_c) begin
            // Direction switch abandons any handshake in flight; latches are kept.
            ibf_nx       = 1'b0;
            intr_nx      = 1'b0;
            overrun_nx   = 1'b0;
            obf_n_nx     = 1'b1;
            in_state_nx  = IN_EMPTY;
            out_state_nx = OUT_EMPTY;
        end else if (mode_in) begin
            case (in_state)
                IN_EMPTY: begin
                    if (stb_fall_c) begin
                        cpu_dout_nx = pd_s;
                        ibf_nx      = 1'b1;
                        in_state_nx = IN_FULL;
                    end
                end
                IN_FULL: begin
                    if (stb_rise_c) intr_nx = inte;
                    if (stb_fall_c) overrun_nx = 1'b1;
                    if (rd_fall_c) begin
                        intr_nx     = 1'b0;
                        in_state_nx = IN_READ;
                    end
                end
                IN_READ: begin
                    if (rd_rise_c) begin
                        overrun_nx = 1'b0;
                        // A strobe coinciding with the end of the read is a fresh capture.
                        if (stb_fall_c) begin
                            cpu_dout_nx = pd_s;
                            in_state_nx = IN_FULL;
                        end else begin
                            ibf_nx      = 1'b0;
                            in_state_nx = IN_EMPTY;
                        end
                    end else if (stb_fall_c) begin
                        overrun_nx = 1'b1;
                    end
                end
                default: in_state_nx = IN_EMPTY;
            endcase
        end else begin
            case (out_state)
                OUT_FULL: begin
                    if (ack_fall_c) begin
                        obf_n_nx     = 1'b1;
                        ack_cnt_nx   = '0;
                        out_state_nx = OUT_ACK;
                    end
                end
                OUT_ACK: begin
                    if (ack_rise_c) begin
                        // Short ACK pulses are treated as glitches and raise no interrupt.
                        if (ack_cnt >= CNT_MIN) intr_nx = inte;
                        out_state_nx = OUT_EMPTY;
                    end else if (!ack_s && (ack_cnt != CNT_MAX)) begin
                        ack_cnt_nx = ack_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            if (wr_fall_c) intr_nx = 1'b0;
            if (wr_rise_c) begin
                pd_out_nx    = cpu_din;
                obf_n_nx     = 1'b0;
                out_state_nx = OUT_FULL;
            end
        end

        if (!inte) intr_nx = 1'b0;
    end

endmodule
